// File: rtl/lane_sum_acc_pkg.sv
// Shared definitions for the lane sum / accumulate block: width helpers and
// mode encoding used by the datapath and the surrounding checksum logic.
package lane_sum_acc_pkg;

  localparam logic MODE_BEAT = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Lossless width of NLANES lanes of W bits plus a carry-in.
  function automatic int sum_width(input int nlanes, input int w);
    return w + clog2(nlanes) + 1;
  endfunction

endpackage

// File: rtl/lane_sum_acc_if.sv
// Valid/ready bundle for the lane sum / accumulate block: input beat side
// and result side. The producer/consumer uses master, the block uses slave.
interface lane_sum_acc_if #(
  parameter int NLANES = 8,
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int BCNT_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NLANES*W-1:0]   in_data;
  logic                  in_cin;
  logic                  in_mode;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_sum;
  logic                  out_zero;
  logic                  out_ovf;
  logic [BCNT_W-1:0]     out_beats;

  modport master (
    output in_valid, in_data, in_cin, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_zero, out_ovf, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_cin, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_zero, out_ovf, out_beats
  );
endinterface

// File: rtl/lane_sum_acc_tree.sv
// Combinational balanced adder tree: NLANES unsigned W-bit lanes plus a
// carry-in, summed losslessly at SW bits. Lanes are padded with zeros up to
// the next power of two so every level halves cleanly.
module lane_sum_tree
  import lane_sum_acc_pkg::*;
#(
  parameter int NLANES = 8,
  parameter int W      = 8,
  parameter int SW     = sum_width(NLANES, W)
) (
  input  logic [NLANES*W-1:0] i_data,
  input  logic                i_cin,
  output logic [SW-1:0]       o_sum
);

  localparam int LVL = clog2(NLANES);
  localparam int NP  = 1 << LVL;

  // Level 0 holds the (padded) lanes; level gi holds NP>>gi partial sums.
  for (genvar gi = 0; gi <= LVL; gi++) begin : g_lvl
    logic [SW-1:0] w_sum [NP >> gi];
    for (genvar gk = 0; gk < (NP >> gi); gk++) begin : g_n
      if (gi == 0) begin : g_leaf
        if (gk < NLANES) begin : g_lane
          assign w_sum[gk] = SW'(i_data[gk*W +: W]);
        end else begin : g_pad
          assign w_sum[gk] = '0;
        end
      end else begin : g_add
        assign w_sum[gk] = g_lvl[gi-1].w_sum[2*gk] + g_lvl[gi-1].w_sum[2*gk+1];
      end
    end
  end

  assign o_sum = g_lvl[LVL].w_sum[0] + SW'(i_cin);

endmodule

// File: rtl/lane_sum_acc.sv
// Two-stage lane sum with accumulate mode. S1 registers the beat sum; S2
// folds it into the accumulator and either emits a result (with zero,
// sticky overflow and beat count) or keeps accumulating until in_last.
module lane_sum_acc
  import lane_sum_acc_pkg::*;
#(
  parameter int NLANES = 8,
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter bit SAT    = 1'b1,
  parameter int BCNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  lane_sum_acc_if.slave bus
);

  localparam int SW = sum_width(NLANES, W);

  if (ACC_W < SW) begin : g_acc_w_chk
    $error("lane_sum_acc: ACC_W must be >= W + clog2(NLANES) + 1");
  end
  if (NLANES < 2) begin : g_nlanes_chk
    $error("lane_sum_acc: NLANES must be >= 2");
  end

  logic              r_ready_en;
  logic              r_s1_valid;
  logic [SW-1:0]     r_s1_sum;
  logic              r_s1_emit;
  logic [ACC_W-1:0]  r_acc;
  logic              r_acc_ovf;
  logic [BCNT_W-1:0] r_cnt;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_sum;
  logic              r_out_zero;
  logic              r_out_ovf;
  logic [BCNT_W-1:0] r_out_beats;

  logic [SW-1:0]     w_beat_sum;
  logic              w_s1_adv;
  logic              w_in_ready;
  logic              w_accept;
  logic [ACC_W:0]    w_sum_ext;
  logic              w_ovf_beat;
  logic [ACC_W-1:0]  w_res;
  logic [BCNT_W-1:0] w_beats;

  lane_sum_tree #(
    .NLANES (NLANES),
    .W      (W),
    .SW     (SW)
  ) u_tree (
    .i_data (bus.in_data),
    .i_cin  (bus.in_cin),
    .o_sum  (w_beat_sum)
  );

  // Accumulate beats never wait on the output; only emitting beats need the
  // result register to be free (or being taken this cycle).
  assign w_s1_adv   = r_s1_valid & (~r_s1_emit | ~r_out_valid | bus.out_ready);
  assign w_in_ready = r_ready_en & ~clr & (~r_s1_valid | w_s1_adv);
  assign w_accept   = bus.in_valid & w_in_ready;

  assign w_sum_ext  = {1'b0, r_acc} + (ACC_W+1)'(r_s1_sum);
  assign w_ovf_beat = w_sum_ext[ACC_W] | r_acc_ovf;
  assign w_res      = (SAT && w_ovf_beat) ? '1 : w_sum_ext[ACC_W-1:0];
  assign w_beats    = (r_cnt == '1) ? r_cnt : r_cnt + BCNT_W'(1);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_zero  = r_out_zero;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_beats = r_out_beats;

  // Hold off in_ready until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready_en <= 1'b0;
    else        r_ready_en <= 1'b1;
  end

  // Stage 1: register the beat sum and whether it closes a packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_emit  <= 1'b0;
    end else if (clr) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_sum   <= w_beat_sum;
      r_s1_emit  <= (bus.in_mode == MODE_BEAT) | bus.in_last;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 state: accumulator, sticky overflow and beat count, cleared when
  // a packet is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
      r_cnt     <= '0;
    end else if (clr || (w_s1_adv && r_s1_emit)) begin
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
      r_cnt     <= '0;
    end else if (w_s1_adv) begin
      r_acc     <= w_res;
      r_acc_ovf <= w_ovf_beat;
      r_cnt     <= w_beats;
    end
  end

  // Result register: loads on an emitting advance (also on the same edge the
  // previous result is taken), otherwise drops valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_zero  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_beats <= '0;
    end else if (clr) begin
      r_out_valid <= 1'b0;
    end else if (w_s1_adv && r_s1_emit) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_res;
      r_out_zero  <= (w_res == '0);
      r_out_ovf   <= w_ovf_beat;
      r_out_beats <= w_beats;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_sum_acc.sv
// Bench for lane_sum_acc: three instances (ACC_W=16 SAT=1, ACC_W=12 SAT=1,
// ACC_W=12 SAT=0) share one stimulus stream; a reference model pushes the
// expected result of each packet into a scoreboard queue, and a monitor pops
// and compares whenever a result is handed over.
module tb_lane_sum_acc;
  import lane_sum_acc_pkg::*;

  localparam int NL = 8;
  localparam int WD = 8;
  localparam int BW = 8;
  localparam int ACCW [3] = '{16, 12, 12};
  localparam bit SATV [3] = '{1'b1, 1'b1, 1'b0};

  typedef struct packed {
    logic [2:0][15:0] sum;
    logic [2:0]       zero;
    logic [2:0]       ovf;
    logic [2:0][7:0]  beats;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr   = 1'b0;
  always #5 clk = ~clk;

  logic              drv_valid = 1'b0;
  logic [NL*WD-1:0]  drv_data  = '0;
  logic              drv_cin   = 1'b0;
  logic              drv_mode  = 1'b0;
  logic              drv_last  = 1'b0;
  logic              drv_oready = 1'b1;

  lane_sum_acc_if #(.NLANES(NL), .W(WD), .ACC_W(16), .BCNT_W(BW)) bus0 ();
  lane_sum_acc_if #(.NLANES(NL), .W(WD), .ACC_W(12), .BCNT_W(BW)) bus1 ();
  lane_sum_acc_if #(.NLANES(NL), .W(WD), .ACC_W(12), .BCNT_W(BW)) bus2 ();

  assign bus0.in_valid = drv_valid;  assign bus1.in_valid = drv_valid;  assign bus2.in_valid = drv_valid;
  assign bus0.in_data  = drv_data;   assign bus1.in_data  = drv_data;   assign bus2.in_data  = drv_data;
  assign bus0.in_cin   = drv_cin;    assign bus1.in_cin   = drv_cin;    assign bus2.in_cin   = drv_cin;
  assign bus0.in_mode  = drv_mode;   assign bus1.in_mode  = drv_mode;   assign bus2.in_mode  = drv_mode;
  assign bus0.in_last  = drv_last;   assign bus1.in_last  = drv_last;   assign bus2.in_last  = drv_last;
  assign bus0.out_ready = drv_oready; assign bus1.out_ready = drv_oready; assign bus2.out_ready = drv_oready;

  lane_sum_acc #(.NLANES(NL), .W(WD), .ACC_W(16), .SAT(1'b1), .BCNT_W(BW)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus0));
  lane_sum_acc #(.NLANES(NL), .W(WD), .ACC_W(12), .SAT(1'b1), .BCNT_W(BW)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus1));
  lane_sum_acc #(.NLANES(NL), .W(WD), .ACC_W(12), .SAT(1'b0), .BCNT_W(BW)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus2));

  logic [2:0]  o_vld, o_rdy, o_zero, o_ovf;
  logic [15:0] o_sum   [3];
  logic [7:0]  o_beats [3];
  assign o_vld  = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
  assign o_rdy  = {bus2.in_ready,  bus1.in_ready,  bus0.in_ready};
  assign o_zero = {bus2.out_zero,  bus1.out_zero,  bus0.out_zero};
  assign o_ovf  = {bus2.out_ovf,   bus1.out_ovf,   bus0.out_ovf};
  assign o_sum[0] = bus0.out_sum;
  assign o_sum[1] = {4'h0, bus1.out_sum};
  assign o_sum[2] = {4'h0, bus2.out_sum};
  assign o_beats[0] = bus0.out_beats;
  assign o_beats[1] = bus1.out_beats;
  assign o_beats[2] = bus2.out_beats;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_pop = 0;
  bit rnd_done = 1'b0;

  exp_t   sb_q [$];
  longint m_acc [3];
  bit     m_ovf [3];
  int     m_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_acc[d] = 0;
      m_ovf[d] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Reference behaviour of one accepted beat; pushes a result when it emits.
  task automatic model_beat(input logic [NL*WD-1:0] data, input logic cin,
                            input logic mode, input logic last);
    int     bs;
    int     beats;
    bit     emit;
    exp_t   e;
    longint ext, lim, res;
    bit     ov;
    bs = int'(cin);
    for (int i = 0; i < NL; i++) bs += int'(data[i*WD +: WD]);
    emit  = (mode == MODE_BEAT) || last;
    beats = (m_cnt >= 255) ? 255 : m_cnt + 1;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      ext = m_acc[d] + longint'(bs);
      lim = 64'd1 << ACCW[d];
      ov  = (ext >= lim) || m_ovf[d];
      res = (SATV[d] && ov) ? lim - 1 : ext % lim;
      if (emit) begin
        e.sum[d]   = 16'(res);
        e.zero[d]  = (res == 0);
        e.ovf[d]   = ov;
        e.beats[d] = 8'(beats);
        m_acc[d]   = 0;
        m_ovf[d]   = 1'b0;
      end else begin
        m_acc[d] = res;
        m_ovf[d] = ov;
      end
    end
    m_cnt = emit ? 0 : beats;
    if (emit) sb_q.push_back(e);
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [NL*WD-1:0] data, input logic cin,
                      input logic mode, input logic last);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    drv_valid = 1'b1;
    drv_data  = data;
    drv_cin   = cin;
    drv_mode  = mode;
    drv_last  = last;
    while (!done) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        model_beat(data, cin, mode, last);
        n_acc++;
        done = 1'b1;
      end else if (++waited > 100) begin
        check_val("accept_timeout", 32'(waited), 32'd0);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
  endtask

  // Scoreboard side: compare every result on the cycle it is handed over.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && !clr && o_vld[0] && drv_oready) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        n_pop++;
        $display("result #%0d: sum=%0d/%0d/%0d beats=%0d ovf=%b zero=%b",
                 n_pop, o_sum[0], o_sum[1], o_sum[2], o_beats[0], o_ovf, o_zero);
        check_val("out_valid_all", 32'(o_vld), 32'd7);
        for (int d = 0; d < 3; d++) begin
          check_val($sformatf("sum%0d", d),   32'(o_sum[d]),   32'(e.sum[d]));
          check_val($sformatf("zero%0d", d),  32'(o_zero[d]),  32'(e.zero[d]));
          check_val($sformatf("ovf%0d", d),   32'(o_ovf[d]),   32'(e.ovf[d]));
          check_val($sformatf("beats%0d", d), 32'(o_beats[d]), 32'(e.beats[d]));
        end
      end
    end
  end

  logic [NL*WD-1:0] lanes;
  int acc0, pop0, guard;

  initial begin
    model_reset();

    // Reset: held low for three cycles, everything quiet.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready",  32'(o_rdy),     32'd0);
    check_val("rst_out_valid", 32'(o_vld),     32'd0);
    check_val("rst_out_sum",   32'(o_sum[0]),  32'd0);
    check_val("rst_out_zero",  32'(o_zero),    32'd0);
    check_val("rst_out_ovf",   32'(o_ovf),     32'd0);
    check_val("rst_out_beats", 32'(o_beats[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("post_rst_in_ready", 32'(o_rdy), 32'd7);
    @(posedge clk); #1;

    // Per-beat sum with latency check: lanes 1..8 + cin = 37.
    lanes = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send(lanes, 1'b1, MODE_BEAT, 1'b0);
    @(negedge clk);
    check_val("lat_s1_only", 32'(o_vld[0]), 32'd0);
    @(negedge clk);
    check_val("lat_out_valid", 32'(o_vld[0]), 32'd1);
    check_val("beat_sum_37",   32'(o_sum[0]), 32'd37);
    @(posedge clk); #1;
    send('0, 1'b0, MODE_BEAT, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Accumulate 3 beats of all 0xFF + cin=1; nothing emitted before last.
    lanes = '1;
    send(lanes, 1'b1, MODE_ACC, 1'b0);
    send(lanes, 1'b1, MODE_ACC, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_val("acc_no_early_out", 32'(o_vld), 32'd0);
    end
    @(posedge clk); #1;
    send(lanes, 1'b1, MODE_ACC, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Overflow case: 3 beats of all 0xFF, cin=0 (6120).
    for (int k = 0; k < 3; k++) send(lanes, 1'b0, MODE_ACC, k == 2);
    repeat (3) @(posedge clk); #1;

    // Mode mixing: an accumulate beat then a per-beat beat closes the packet.
    send({8{8'd3}}, 1'b0, MODE_ACC, 1'b0);
    send({8{8'd2}}, 1'b1, MODE_BEAT, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Beat counter saturation: 300 accumulate beats of cin only.
    for (int k = 0; k < 300; k++) send('0, 1'b1, MODE_ACC, k == 299);
    repeat (3) @(posedge clk); #1;

    // Backpressure: 6 per-beat beats with out_ready low, then released.
    drv_oready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send({$urandom, $urandom}, 1'($urandom_range(0, 1)), MODE_BEAT, 1'b0);
      end
      begin
        repeat (4) @(posedge clk); #1;
        check_val("bp_hold_sum_a", 32'(o_sum[0]), 32'(sb_q[0].sum[0]));
        repeat (4) @(posedge clk); #1;
        check_val("bp_accepted",   32'(n_acc - acc0), 32'd2);
        check_val("bp_in_ready",   32'(o_rdy), 32'd0);
        check_val("bp_out_valid",  32'(o_vld), 32'd7);
        check_val("bp_hold_sum_b", 32'(o_sum[0]), 32'(sb_q[0].sum[0]));
        drv_oready = 1'b1;
        pop0 = n_pop;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        check_val("bp_delivered", 32'(n_pop - pop0), 32'd6);
        @(negedge clk);
        check_val("bp_no_dup", 32'(o_vld[0]), 32'd0);
      end
    join
    @(posedge clk); #1;

    // Mixed random traffic with random output backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++)
          send({$urandom, $urandom}, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        send({$urandom, $urandom}, 1'b0, MODE_ACC, 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          drv_oready = 1'($urandom_range(0, 1));
        end
      end
    join
    drv_oready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val("rnd_drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk); #1;

    // clr mid-packet: the accumulated beats must vanish.
    send({8{8'h10}}, 1'b0, MODE_ACC, 1'b0);
    send({8{8'h10}}, 1'b0, MODE_ACC, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    check_val("clr_in_ready", 32'(o_rdy), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    model_reset();
    sb_q.delete();
    check_val("clr_out_valid", 32'(o_vld), 32'd0);
    send({8{8'd1}}, 1'b0, MODE_BEAT, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_val("clr_sum_8",   32'(o_sum[0]),   32'd8);
    check_val("clr_beats_1", 32'(o_beats[0]), 32'd1);
    repeat (3) @(posedge clk); #1;
    check_val("final_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
